// File: rtl/apb_uart_fifo_if.sv
// APB3 slave bus bundle for the UART block; the requester drives the master modport.
interface apb_uart_fifo_if;
    logic       PSEL;
    logic       PENABLE;
    logic [7:0] PADDR;
    logic       PWRITE;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA;
    logic       PREADY;
    logic       PSLVERR;

    modport master (
        output PSEL, PENABLE, PADDR, PWRITE, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PADDR, PWRITE, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_uart_fifo.sv
// APB-mapped UART: TX/RX FIFOs, programmable baud divisor, 16x RX oversampling,
// optional parity, one or two stop bits, sticky error flags and a level interrupt.
module apb_uart_fifo #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [15:0] DIV_RST    = 16'd27
) (
    input  logic           PCLK,
    input  logic           PRESET,
    apb_uart_fifo_if.slave apb,
    input  logic           rx,
    output logic           tx,
    output logic           rx_done,
    output logic           tx_done,
    output logic           irq
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PtrOne = (AW + 1)'(1);
    localparam logic [2:0]  LastBit = 3'(DATA_W - 1);

    localparam logic [7:0] AddrData   = 8'h00;
    localparam logic [7:0] AddrStatus = 8'h04;
    localparam logic [7:0] AddrCtrl   = 8'h08;
    localparam logic [7:0] AddrDivLo  = 8'h0C;
    localparam logic [7:0] AddrDivHi  = 8'h10;

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StStart  = 3'd1;
    localparam logic [2:0] StData   = 3'd2;
    localparam logic [2:0] StParity = 3'd3;
    localparam logic [2:0] StStop   = 3'd4;

    // APB decode
    logic       access, slverr;
    logic [7:0] rdata, status;
    logic       tx_push, rx_pop, status_rd, ctrl_we, div_lo_we, div_hi_we;

    // Control, divisor and baud counter
    logic [5:0]  ctrl_q, ctrl_d;
    logic [15:0] div_q, div_d, baud_cnt_q, baud_cnt_d;
    logic        tick;

    // FIFOs
    logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
    logic [AW:0]       tx_wptr_q, tx_rptr_q, rx_wptr_q, rx_rptr_q;
    logic              tx_empty, tx_full, rx_empty, rx_full;
    logic [DATA_W-1:0] tx_head;
    logic              tx_pop;

    // Transmitter
    logic [2:0]        tx_state_q, tx_state_d;
    logic [3:0]        tx_os_q, tx_os_d;
    logic [2:0]        tx_bit_q, tx_bit_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic              tx_par_q, tx_par_d, tx_par_en_q, tx_par_en_d;
    logic              tx_two_stop_q, tx_two_stop_d, tx_stop2_q, tx_stop2_d;
    logic              tx_done_q, tx_done_d, tx_start;

    // Receiver
    logic              rx_s1_q, rx_s2_q, rx_s3_q, rx_fall;
    logic [2:0]        rx_state_q, rx_state_d;
    logic [3:0]        rx_os_q, rx_os_d;
    logic [2:0]        rx_bit_q, rx_bit_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic              rx_par_en_q, rx_par_en_d, rx_odd_q, rx_odd_d, rx_perr_q, rx_perr_d;
    logic              rx_push, rx_push_ok, overrun_evt, rx_done_q;

    // Sticky errors
    logic overrun_q, overrun_d, parity_err_q, parity_err_d, frame_err_q, frame_err_d;

    // ---------------------------------------------------------------- APB
    assign access = apb.PSEL & apb.PENABLE & ~PRESET;
    assign status = {tx_state_q != StIdle, frame_err_q, parity_err_q, overrun_q,
                     tx_full, tx_empty, rx_full, rx_empty};

    always_comb begin
        rdata     = '0;
        slverr    = 1'b0;
        tx_push   = 1'b0;
        rx_pop    = 1'b0;
        status_rd = 1'b0;
        ctrl_we   = 1'b0;
        div_lo_we = 1'b0;
        div_hi_we = 1'b0;
        if (access) begin
            case (apb.PADDR)
                AddrData: begin
                    if (apb.PWRITE) begin
                        if (tx_full) slverr = 1'b1;
                        else         tx_push = 1'b1;
                    end else if (rx_empty) begin
                        slverr = 1'b1;
                    end else begin
                        rx_pop = 1'b1;
                        rdata  = 8'(rx_mem[rx_rptr_q[AW-1:0]]);
                    end
                end
                AddrStatus: begin
                    if (apb.PWRITE) begin
                        slverr = 1'b1;
                    end else begin
                        rdata     = status;
                        status_rd = 1'b1;
                    end
                end
                AddrCtrl: begin
                    if (apb.PWRITE) ctrl_we = 1'b1;
                    else            rdata = {2'b00, ctrl_q};
                end
                AddrDivLo: begin
                    if (apb.PWRITE) div_lo_we = 1'b1;
                    else            rdata = div_q[7:0];
                end
                AddrDivHi: begin
                    if (apb.PWRITE) div_hi_we = 1'b1;
                    else            rdata = div_q[15:8];
                end
                default: slverr = 1'b1;
            endcase
        end
    end

    assign apb.PRDATA  = rdata;
    assign apb.PSLVERR = slverr;
    assign apb.PREADY  = 1'b1;

    // ------------------------------------------------- control and baud
    assign tick = (baud_cnt_q == 16'd0);

    always_comb begin
        ctrl_d = ctrl_q;
        div_d  = div_q;
        if (ctrl_we)   ctrl_d       = apb.PWDATA[5:0];
        if (div_lo_we) div_d[7:0]   = apb.PWDATA;
        if (div_hi_we) div_d[15:8]  = apb.PWDATA;
        // A divisor write restarts the tick period right away.
        if (div_lo_we || div_hi_we) baud_cnt_d = div_d;
        else if (tick)              baud_cnt_d = div_q;
        else                        baud_cnt_d = baud_cnt_q - 16'd1;
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            ctrl_q     <= '0;
            div_q      <= DIV_RST;
            baud_cnt_q <= DIV_RST;
        end else begin
            ctrl_q     <= ctrl_d;
            div_q      <= div_d;
            baud_cnt_q <= baud_cnt_d;
        end
    end

    // -------------------------------------------------------------- FIFOs
    assign tx_empty = (tx_wptr_q == tx_rptr_q);
    assign tx_full  = (tx_wptr_q[AW] != tx_rptr_q[AW]) &&
                      (tx_wptr_q[AW-1:0] == tx_rptr_q[AW-1:0]);
    assign rx_empty = (rx_wptr_q == rx_rptr_q);
    assign rx_full  = (rx_wptr_q[AW] != rx_rptr_q[AW]) &&
                      (rx_wptr_q[AW-1:0] == rx_rptr_q[AW-1:0]);
    assign tx_head  = tx_mem[tx_rptr_q[AW-1:0]];

    // A same-cycle APB pop frees the slot a full RX FIFO needs.
    assign rx_push_ok  = rx_push & (~rx_full | rx_pop);
    assign overrun_evt = rx_push & rx_full & ~rx_pop;

    always_ff @(posedge PCLK) begin
        if (tx_push)    tx_mem[tx_wptr_q[AW-1:0]] <= apb.PWDATA[DATA_W-1:0];
        if (rx_push_ok) rx_mem[rx_wptr_q[AW-1:0]] <= rx_shift_q;
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
        end else begin
            if (tx_push)    tx_wptr_q <= tx_wptr_q + PtrOne;
            if (tx_pop)     tx_rptr_q <= tx_rptr_q + PtrOne;
            if (rx_push_ok) rx_wptr_q <= rx_wptr_q + PtrOne;
            if (rx_pop)     rx_rptr_q <= rx_rptr_q + PtrOne;
        end
    end

    // -------------------------------------------------------- transmitter
    always_comb begin
        tx_state_d    = tx_state_q;
        tx_os_d       = tx_os_q;
        tx_bit_d      = tx_bit_q;
        tx_shift_d    = tx_shift_q;
        tx_par_d      = tx_par_q;
        tx_par_en_d   = tx_par_en_q;
        tx_two_stop_d = tx_two_stop_q;
        tx_stop2_d    = tx_stop2_q;
        tx_done_d     = 1'b0;
        tx_start      = 1'b0;
        tx_pop        = 1'b0;
        if (tick) begin
            if (tx_state_q == StIdle) begin
                tx_start = ~tx_empty;
            end else begin
                tx_os_d = tx_os_q + 4'd1;
                if (tx_os_q == 4'd15) begin
                    case (tx_state_q)
                        StStart: begin
                            tx_state_d = StData;
                            tx_bit_d   = '0;
                        end
                        StData: begin
                            tx_shift_d = tx_shift_q >> 1;
                            if (tx_bit_q == LastBit) tx_state_d = tx_par_en_q ? StParity : StStop;
                            else                     tx_bit_d   = tx_bit_q + 3'd1;
                        end
                        StParity: tx_state_d = StStop;
                        StStop: begin
                            if (tx_two_stop_q && !tx_stop2_q) begin
                                tx_stop2_d = 1'b1;
                            end else begin
                                tx_done_d  = 1'b1;
                                tx_state_d = StIdle;
                                // Chain straight into the next frame with no idle bit.
                                tx_start   = ~tx_empty;
                            end
                        end
                        default: tx_state_d = StIdle;
                    endcase
                end
            end
        end
        if (tx_start) begin
            tx_pop        = 1'b1;
            tx_state_d    = StStart;
            tx_os_d       = '0;
            tx_shift_d    = tx_head;
            tx_par_d      = ^tx_head ^ ctrl_q[1];
            tx_par_en_d   = ctrl_q[0];
            tx_two_stop_d = ctrl_q[2];
            tx_stop2_d    = 1'b0;
        end
    end

    always_comb begin
        case (tx_state_q)
            StStart:  tx = 1'b0;
            StData:   tx = tx_shift_q[0];
            StParity: tx = tx_par_q;
            default:  tx = 1'b1;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            tx_state_q    <= StIdle;
            tx_os_q       <= '0;
            tx_bit_q      <= '0;
            tx_shift_q    <= '0;
            tx_par_q      <= 1'b0;
            tx_par_en_q   <= 1'b0;
            tx_two_stop_q <= 1'b0;
            tx_stop2_q    <= 1'b0;
            tx_done_q     <= 1'b0;
        end else begin
            tx_state_q    <= tx_state_d;
            tx_os_q       <= tx_os_d;
            tx_bit_q      <= tx_bit_d;
            tx_shift_q    <= tx_shift_d;
            tx_par_q      <= tx_par_d;
            tx_par_en_q   <= tx_par_en_d;
            tx_two_stop_q <= tx_two_stop_d;
            tx_stop2_q    <= tx_stop2_d;
            tx_done_q     <= tx_done_d;
        end
    end

    // ----------------------------------------------------------- receiver
    assign rx_fall = rx_s3_q & ~rx_s2_q;

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_os_d     = rx_os_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_par_en_d = rx_par_en_q;
        rx_odd_d    = rx_odd_q;
        rx_perr_d   = rx_perr_q;
        rx_push     = 1'b0;
        if (rx_state_q == StIdle) begin
            if (rx_fall) begin
                rx_state_d  = StStart;
                rx_os_d     = '0;
                rx_bit_d    = '0;
                rx_par_en_d = ctrl_q[0];
                rx_odd_d    = ctrl_q[1];
                rx_perr_d   = 1'b0;
            end
        end else if (tick) begin
            rx_os_d = rx_os_q + 4'd1;
            if (rx_os_q == 4'd7) begin
                // Mid-bit sample point.
                case (rx_state_q)
                    StStart:  if (rx_s2_q) rx_state_d = StIdle;
                    StData:   rx_shift_d = {rx_s2_q, rx_shift_q[DATA_W-1:1]};
                    StParity: rx_perr_d  = rx_s2_q != (^rx_shift_q ^ rx_odd_q);
                    default: begin
                        rx_push    = 1'b1;
                        rx_state_d = StIdle;
                    end
                endcase
            end else if (rx_os_q == 4'd15) begin
                case (rx_state_q)
                    StStart: rx_state_d = StData;
                    StData: begin
                        if (rx_bit_q == LastBit) rx_state_d = rx_par_en_q ? StParity : StStop;
                        else                     rx_bit_d   = rx_bit_q + 3'd1;
                    end
                    StParity: rx_state_d = StStop;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            rx_s3_q     <= 1'b1;
            rx_state_q  <= StIdle;
            rx_os_q     <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            rx_par_en_q <= 1'b0;
            rx_odd_q    <= 1'b0;
            rx_perr_q   <= 1'b0;
            rx_done_q   <= 1'b0;
        end else begin
            rx_s1_q     <= rx;
            rx_s2_q     <= rx_s1_q;
            rx_s3_q     <= rx_s2_q;
            rx_state_q  <= rx_state_d;
            rx_os_q     <= rx_os_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            rx_par_en_q <= rx_par_en_d;
            rx_odd_q    <= rx_odd_d;
            rx_perr_q   <= rx_perr_d;
            rx_done_q   <= rx_push_ok;
        end
    end

    // ------------------------------------------------ sticky errors, irq
    always_comb begin
        overrun_d    = (overrun_q    & ~status_rd) | overrun_evt;
        parity_err_d = (parity_err_q & ~status_rd) | (rx_push & rx_perr_q);
        frame_err_d  = (frame_err_q  & ~status_rd) | (rx_push & ~rx_s2_q);
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            overrun_q    <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            overrun_q    <= overrun_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign irq = (ctrl_q[3] & ~rx_empty) | (ctrl_q[4] & tx_empty) |
                 (ctrl_q[5] & (overrun_q | parity_err_q | frame_err_q));

    assign rx_done = rx_done_q;
    assign tx_done = tx_done_q;
endmodule

// File: tb/tb_apb_uart_fifo.sv
// Directed self-checking bench for apb_uart_fifo: register map, TX framing, loopback,
// FIFO full/overrun, frame error, glitch rejection and mid-frame reset.
module tb_apb_uart_fifo;
    logic PCLK    = 1'b0;
    logic PRESET  = 1'b1;
    logic rx_drv  = 1'b1;
    logic loop_en = 1'b0;
    logic rx, tx, rx_done, tx_done, irq;

    int checks = 0;
    int errors = 0;
    int rx_done_cnt = 0;
    int tx_done_cnt = 0;

    apb_uart_fifo_if bus ();

    assign rx = loop_en ? tx : rx_drv;

    apb_uart_fifo #(
        .DATA_W    (8),
        .FIFO_DEPTH(16),
        .DIV_RST   (16'd27)
    ) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .apb    (bus),
        .rx     (rx),
        .tx     (tx),
        .rx_done(rx_done),
        .tx_done(tx_done),
        .irq    (irq)
    );

    always #5 PCLK = ~PCLK;

    always @(negedge PCLK) begin
        if (rx_done) rx_done_cnt <= rx_done_cnt + 1;
        if (tx_done) tx_done_cnt <= tx_done_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    task automatic apb_xfer(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                            output logic [7:0] rdata, output logic err);
        @(posedge PCLK);
        #1;
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PADDR   = addr;
        bus.PWRITE  = wr;
        bus.PWDATA  = wdata;
        @(posedge PCLK);
        #1;
        bus.PENABLE = 1'b1;
        #3;
        rdata = bus.PRDATA;
        err   = bus.PSLVERR;
        @(posedge PCLK);
        #1;
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
    endtask

    task automatic wr_chk(input string tag, input logic [7:0] addr, input logic [7:0] wdata,
                          input logic exp_err);
        logic [7:0] d;
        logic       e;
        apb_xfer(1'b1, addr, wdata, d, e);
        check(tag, {31'd0, e}, {31'd0, exp_err});
    endtask

    // Compares {PSLVERR, PRDATA} in one go.
    task automatic rd_chk(input string tag, input logic [7:0] addr, input logic [7:0] exp_data,
                          input logic exp_err);
        logic [7:0] d;
        logic       e;
        apb_xfer(1'b0, addr, 8'h00, d, e);
        check(tag, {23'd0, e, d}, {23'd0, exp_err, exp_data});
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop);
        rx_drv = 1'b0;
        cyc(16);
        for (int i = 0; i < 8; i++) begin
            rx_drv = data[i];
            cyc(16);
        end
        rx_drv = stop;
        cyc(16);
        rx_drv = 1'b1;
        cyc(16);
    endtask

    task automatic wait_tx_start(input string tag);
        int n;
        n = 0;
        while (tx !== 1'b0 && n < 200) begin
            cyc(1);
            n++;
        end
        check(tag, {31'd0, n < 200}, 32'd1);
    endtask

    initial begin
        logic [9:0] frame;
        logic [7:0] d;
        logic       e;
        int         bad, n, base, done_at, done_n, low;

        // Reset, with a live STATUS access to prove outputs stay quiet.
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b1;
        bus.PADDR   = 8'h04;
        bus.PWRITE  = 1'b0;
        bus.PWDATA  = 8'h00;
        cyc(3);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_outs", {20'd0, rx_done, tx_done, irq, bus.PRDATA, bus.PSLVERR}, 32'd0);
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        PRESET      = 1'b0;
        cyc(2);
        rd_chk("rst_status", 8'h04, 8'h05, 1'b0);
        rd_chk("rst_ctrl", 8'h08, 8'h00, 1'b0);
        rd_chk("rst_div_lo", 8'h0C, 8'h1B, 1'b0);
        rd_chk("rst_div_hi", 8'h10, 8'h00, 1'b0);
        check("pready", {31'd0, bus.PREADY}, 32'd1);
        rd_chk("bad_addr", 8'h14, 8'h00, 1'b1);
        wr_chk("wr_status", 8'h04, 8'hFF, 1'b1);
        rd_chk("rd_empty", 8'h00, 8'h00, 1'b1);

        // DIV=0, send 0x2A and check every bit cell and the tx_done position.
        wr_chk("div_lo0", 8'h0C, 8'h00, 1'b0);
        wr_chk("data_2a", 8'h00, 8'h2A, 1'b0);
        wait_tx_start("tx_start_2a");
        frame   = {1'b1, 8'h2A, 1'b0};
        bad     = 0;
        done_at = -1;
        done_n  = 0;
        for (int c = 0; c < 176; c++) begin
            if (c < 160 && tx !== frame[c / 16]) bad++;
            if (c < 160 && c % 16 == 8) check($sformatf("tx_bit%0d", c / 16), {31'd0, tx},
                                               {31'd0, frame[c / 16]});
            if (tx_done) begin
                done_n++;
                if (done_at < 0) done_at = c;
            end
            cyc(1);
        end
        check("tx_bit_width", bad, 0);
        check("tx_done_cycle", done_at, 160);
        check("tx_done_count", done_n, 1);

        // Loopback with odd parity and RX interrupt.
        wr_chk("ctrl_par_odd", 8'h08, 8'h0B, 1'b0);
        rd_chk("ctrl_read", 8'h08, 8'h0B, 1'b0);
        loop_en = 1'b1;
        base    = rx_done_cnt;
        wr_chk("data_a5", 8'h00, 8'hA5, 1'b0);
        n = 0;
        while (rx_done_cnt == base && n < 400) begin
            cyc(1);
            n++;
        end
        check("loop_rx_done", rx_done_cnt - base, 1);
        check("irq_rx", {31'd0, irq}, 32'd1);
        rd_chk("loop_data", 8'h00, 8'hA5, 1'b0);
        check("irq_clr", {31'd0, irq}, 32'd0);
        apb_xfer(1'b0, 8'h04, 8'h00, d, e);
        check("loop_errs", {29'd0, d[6:4]}, 32'd0);
        cyc(40);
        loop_en = 1'b0;

        // Stop bit of 0 sets frame_err; a STATUS read clears it.
        wr_chk("ctrl_clr", 8'h08, 8'h00, 1'b0);
        send_frame(8'h3C, 1'b0);
        rd_chk("ferr_status", 8'h04, 8'h44, 1'b0);
        rd_chk("ferr_clear", 8'h04, 8'h04, 1'b0);
        rd_chk("ferr_data", 8'h00, 8'h3C, 1'b0);

        // Short low glitch on idle rx is rejected.
        base   = rx_done_cnt;
        rx_drv = 1'b0;
        cyc(4);
        rx_drv = 1'b1;
        cyc(40);
        check("glitch_rx_done", rx_done_cnt - base, 0);
        rd_chk("glitch_status", 8'h04, 8'h05, 1'b0);

        // FIFO_DEPTH+1 frames without reading: overrun, first entry kept.
        base = rx_done_cnt;
        for (int k = 0; k < 17; k++) send_frame(8'(8'h10 + k), 1'b1);
        check("ovr_rx_done", rx_done_cnt - base, 16);
        rd_chk("ovr_status", 8'h04, 8'h16, 1'b0);
        rd_chk("ovr_status_clr", 8'h04, 8'h06, 1'b0);
        rd_chk("ovr_first", 8'h00, 8'h10, 1'b0);
        bad = 0;
        for (int k = 1; k < 16; k++) begin
            apb_xfer(1'b0, 8'h00, 8'h00, d, e);
            if ({e, d} !== {1'b0, 8'(8'h10 + k)}) bad++;
        end
        check("ovr_drain", bad, 0);
        rd_chk("ovr_empty", 8'h00, 8'h00, 1'b1);

        // TX FIFO full while the baud tick is stalled by a huge divisor.
        wr_chk("div_lo_ff", 8'h0C, 8'hFF, 1'b0);
        wr_chk("div_hi_ff", 8'h10, 8'hFF, 1'b0);
        bad = 0;
        for (int k = 0; k < 16; k++) begin
            apb_xfer(1'b1, 8'h00, 8'(k), d, e);
            if (e) bad++;
        end
        check("txf_no_err", bad, 0);
        wr_chk("txf_overflow", 8'h00, 8'hEE, 1'b1);
        rd_chk("txf_status", 8'h04, 8'h09, 1'b0);
        base = tx_done_cnt;
        wr_chk("div_lo_0b", 8'h0C, 8'h00, 1'b0);
        wr_chk("div_hi_0b", 8'h10, 8'h00, 1'b0);
        n = 0;
        while (tx_done_cnt - base < 16 && n < 4000) begin
            cyc(1);
            n++;
        end
        cyc(400);
        check("txf_frames", tx_done_cnt - base, 16);
        rd_chk("txf_idle_status", 8'h04, 8'h05, 1'b0);

        // Reset during data bit 3 (0x55 bit 3 = 0) releases tx asynchronously.
        wr_chk("data_55", 8'h00, 8'h55, 1'b0);
        wait_tx_start("tx_start_55");
        cyc(72);
        check("mid_bit3", {31'd0, tx}, 32'd0);
        #2;
        PRESET = 1'b1;
        #1;
        check("rst_async_tx", {31'd0, tx}, 32'd1);
        cyc(2);
        PRESET = 1'b0;
        cyc(2);
        rd_chk("rst_status_after", 8'h04, 8'h05, 1'b0);
        rd_chk("rst_div_after", 8'h0C, 8'h1B, 1'b0);
        low = 0;
        for (int c = 0; c < 600; c++) begin
            if (tx !== 1'b1) low++;
            cyc(1);
        end
        check("no_stale_frame", low, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
